// File: rtl/fb_write_arbiter.sv
// rtl/fb_write_arbiter.sv - frame-buffer write-port arbiter: camera stream vs rectangle fill
// Optional FB_CLIP_EN drops writes whose (x,y) falls outside the screen.
module fb_write_arbiter #(
  parameter int SCREEN_W   = 176,
  parameter int SCREEN_H   = 144,
  parameter int ADDR_W     = 15,
  parameter int DATA_W     = 32,
  parameter int MAX_STARVE = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cam_valid,
  output logic              cam_ready,
  input  logic [7:0]        cam_x,
  input  logic [7:0]        cam_y,
  input  logic [DATA_W-1:0] cam_data,
  input  logic              fill_start,
  input  logic [7:0]        fill_x0,
  input  logic [7:0]        fill_y0,
  input  logic [7:0]        fill_w,
  input  logic [7:0]        fill_h,
  input  logic [DATA_W-1:0] fill_color,
  output logic              fill_busy,
  output logic              fill_done,
  output logic [ADDR_W-1:0] w_addr,
  output logic [DATA_W-1:0] w_data,
  output logic              w_en
);

  localparam logic [1:0]  S_IDLE = 2'd0;
  localparam logic [1:0]  S_FILL = 2'd1;
  localparam logic [1:0]  S_DONE = 2'd2;
  localparam logic [3:0]  LP_MAX = 4'(MAX_STARVE);
  localparam logic [15:0] LP_SW  = 16'(SCREEN_W);

  logic [1:0]        r_state;
  logic [3:0]        r_starve;
  logic [8:0]        r_x0;
  logic [8:0]        r_x_end;
  logic [8:0]        r_y_end;
  logic [8:0]        r_cx;
  logic [8:0]        r_cy;
  logic [DATA_W-1:0] r_color;
  logic [ADDR_W-1:0] r_w_addr;
  logic [DATA_W-1:0] r_w_data;
  logic              r_w_en;

  logic              w_fill_pend;
  logic              w_fill_grant;
  logic              w_cam_accept;
  logic              w_last_col;
  logic              w_last_pix;
  logic              w_cmd_ok;
  logic [8:0]        w_sel_x;
  logic [8:0]        w_sel_y;
  logic [ADDR_W-1:0] w_sel_addr;
  logic              w_in_range;

  // y*SCREEN_W + x as a sum of shifted rows, one adder per set bit of SCREEN_W.
  function automatic logic [ADDR_W-1:0] f_addr(input logic [8:0] x, input logic [8:0] y);
    logic [31:0] acc;
    acc = {23'd0, x};
    for (int i = 0; i < 16; i++) begin
      if (LP_SW[i]) acc = acc + ({23'd0, y} << i);
    end
    return acc[ADDR_W-1:0];
  endfunction

  assign w_fill_pend  = (r_state == S_FILL);
  assign w_fill_grant = w_fill_pend && (!cam_valid || (r_starve == LP_MAX));
  assign w_cam_accept = cam_valid && !w_fill_grant;
  assign w_last_col   = (r_cx == r_x_end);
  assign w_last_pix   = w_last_col && (r_cy == r_y_end);
  assign w_cmd_ok     = (fill_w != 8'd0) && (fill_h != 8'd0);

  assign w_sel_x    = w_fill_grant ? r_cx : {1'b0, cam_x};
  assign w_sel_y    = w_fill_grant ? r_cy : {1'b0, cam_y};
  assign w_sel_addr = f_addr(w_sel_x, w_sel_y);

`ifdef FB_CLIP_EN
  assign w_in_range = ({23'd0, w_sel_x} < 32'(SCREEN_W)) && ({23'd0, w_sel_y} < 32'(SCREEN_H));
`else
  assign w_in_range = 1'b1;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_x0    <= '0;
      r_x_end <= '0;
      r_y_end <= '0;
      r_cx    <= '0;
      r_cy    <= '0;
      r_color <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (fill_start) begin
            if (w_cmd_ok) begin
              r_state <= S_FILL;
              r_x0    <= {1'b0, fill_x0};
              r_x_end <= {1'b0, fill_x0} + {1'b0, fill_w} - 9'd1;
              r_y_end <= {1'b0, fill_y0} + {1'b0, fill_h} - 9'd1;
              r_cx    <= {1'b0, fill_x0};
              r_cy    <= {1'b0, fill_y0};
              r_color <= fill_color;
            end else begin
              r_state <= S_DONE;
            end
          end
        end
        S_FILL: begin
          if (w_fill_grant) begin
            if (w_last_pix) begin
              r_state <= S_DONE;
            end else if (w_last_col) begin
              r_cx <= r_x0;
              r_cy <= r_cy + 9'd1;
            end else begin
              r_cx <= r_cx + 9'd1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Counts camera wins while a fill pixel waits; reaching MAX_STARVE forces a fill slot.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_starve <= '0;
    end else if (!w_fill_pend || w_fill_grant) begin
      r_starve <= '0;
    end else if (w_cam_accept && (r_starve != LP_MAX)) begin
      r_starve <= r_starve + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_w_en   <= 1'b0;
      r_w_addr <= '0;
      r_w_data <= '0;
    end else begin
      r_w_en <= (w_fill_grant || w_cam_accept) && w_in_range;
      if (w_fill_grant || w_cam_accept) begin
        r_w_addr <= w_sel_addr;
        r_w_data <= w_fill_grant ? r_color : cam_data;
      end
    end
  end

  assign cam_ready = !w_fill_grant;
  assign fill_busy = (r_state == S_FILL);
  assign fill_done = (r_state == S_DONE);
  assign w_addr    = r_w_addr;
  assign w_data    = r_w_data;
  assign w_en      = r_w_en;

endmodule

// File: tb/tb_fb_write_arbiter.sv
// tb/tb_fb_write_arbiter.sv - directed self-checking bench for fb_write_arbiter
module tb_fb_write_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cam_valid;
  logic        cam_ready;
  logic [7:0]  cam_x, cam_y;
  logic [31:0] cam_data;
  logic        fill_start;
  logic [7:0]  fill_x0, fill_y0, fill_w, fill_h;
  logic [31:0] fill_color;
  logic        fill_busy, fill_done;
  logic [14:0] w_addr;
  logic [31:0] w_data;
  logic        w_en;

  int checks = 0;
  int errors = 0;

  fb_write_arbiter dut (
    .clk(clk), .reset_n(reset_n),
    .cam_valid(cam_valid), .cam_ready(cam_ready),
    .cam_x(cam_x), .cam_y(cam_y), .cam_data(cam_data),
    .fill_start(fill_start), .fill_x0(fill_x0), .fill_y0(fill_y0),
    .fill_w(fill_w), .fill_h(fill_h), .fill_color(fill_color),
    .fill_busy(fill_busy), .fill_done(fill_done),
    .w_addr(w_addr), .w_data(w_data), .w_en(w_en)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic start_fill(input logic [7:0] x0, input logic [7:0] y0,
                            input logic [7:0] w, input logic [7:0] h, input logic [31:0] col);
    fill_start = 1'b1; fill_x0 = x0; fill_y0 = y0; fill_w = w; fill_h = h; fill_color = col;
    cyc();
    fill_start = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; cam_valid = 1'b0; cam_x = '0; cam_y = '0; cam_data = '0;
    fill_start = 1'b0; fill_x0 = '0; fill_y0 = '0; fill_w = '0; fill_h = '0; fill_color = '0;
    #12;
    checks++;
    if ({w_en, fill_busy, fill_done} !== 3'b000 || w_addr !== 15'd0 || w_data !== 32'd0) begin
      errors++;
      $display("FAIL reset_outputs: en/busy/done=%b addr=%0d data=%h, required 000/0/0",
               {w_en, fill_busy, fill_done}, w_addr, w_data);
    end
    cyc();
    reset_n = 1'b1;
    cyc();
    checks++;
    if (w_en !== 1'b0 || cam_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_idle: w_en=%b cam_ready=%b, required 0/1", w_en, cam_ready);
    end
  endtask

  task automatic test_camera();
    cam_valid = 1'b1; cam_x = 8'd5; cam_y = 8'd2; cam_data = 32'hAABBCCDD;
    #1;
    checks++;
    if (cam_ready !== 1'b1) begin
      errors++; $display("FAIL cam_ready: got %b, required 1", cam_ready);
    end
    cyc();
    cam_valid = 1'b0;
    checks++;
    if (w_en !== 1'b1 || w_addr !== 15'd357 || w_data !== 32'hAABBCCDD) begin
      errors++;
      $display("FAIL cam_write: en=%b addr=%0d data=%h, required 1/357/aabbccdd", w_en, w_addr, w_data);
    end
    cyc();
    checks++;
    if (w_en !== 1'b0 || w_addr !== 15'd357) begin
      errors++; $display("FAIL cam_idle_hold: en=%b addr=%0d, required 0/357", w_en, w_addr);
    end
  endtask

  // Also pulses a conflicting fill_start mid-fill when ignore_probe=1.
  task automatic test_fill(input bit ignore_probe);
    logic [14:0] exp_addr [6];
    exp_addr = '{15'd538, 15'd539, 15'd540, 15'd714, 15'd715, 15'd716};
    start_fill(8'd10, 8'd3, 8'd3, 8'd2, 32'h00FF00FF);
    checks++;
    if (fill_busy !== 1'b1) begin
      errors++; $display("FAIL fill_busy_start: got %b, required 1", fill_busy);
    end
    for (int k = 0; k < 6; k++) begin
      if (ignore_probe && k == 1) begin
        fill_start = 1'b1; fill_x0 = 8'd100; fill_y0 = 8'd50; fill_w = 8'd2; fill_h = 8'd2;
        fill_color = 32'h12345678;
      end
      cyc();
      fill_start = 1'b0;
      checks++;
      if (w_en !== 1'b1 || w_addr !== exp_addr[k] || w_data !== 32'h00FF00FF) begin
        errors++;
        $display("FAIL fill_write[%0d]: en=%b addr=%0d data=%h, required 1/%0d/00ff00ff",
                 k, w_en, w_addr, w_data, exp_addr[k]);
      end
      checks++;
      if (fill_done !== (k == 5) || fill_busy !== (k != 5)) begin
        errors++;
        $display("FAIL fill_flags[%0d]: done=%b busy=%b, required %b/%b",
                 k, fill_done, fill_busy, k == 5, k != 5);
      end
    end
    cyc();
    checks++;
    if (fill_done !== 1'b0 || w_en !== 1'b0 || fill_busy !== 1'b0) begin
      errors++;
      $display("FAIL fill_after: done=%b en=%b busy=%b, required 0/0/0", fill_done, w_en, fill_busy);
    end
  endtask

  task automatic test_contention();
    logic [9:0]  fpat;
    logic [14:0] exp_a;
    logic [31:0] exp_d;
    int          ncam;
    int          nfill;
    fpat = 10'b10_0001_0000;
    ncam = 0; nfill = 0;
    start_fill(8'd0, 8'd0, 8'd2, 8'd1, 32'hF00DF00D);
    for (int i = 0; i < 10; i++) begin
      cam_valid = 1'b1; cam_x = 8'(20 + ncam); cam_y = 8'd10; cam_data = 32'(ncam);
      #1;
      checks++;
      if (cam_ready !== !fpat[i]) begin
        errors++; $display("FAIL cont_ready[%0d]: got %b, required %b", i, cam_ready, !fpat[i]);
      end
      if (fpat[i]) begin
        exp_a = 15'(nfill); exp_d = 32'hF00DF00D; nfill++;
      end else begin
        exp_a = 15'(1760 + 20 + ncam); exp_d = 32'(ncam); ncam++;
      end
      cyc();
      checks++;
      if (w_en !== 1'b1 || w_addr !== exp_a || w_data !== exp_d) begin
        errors++;
        $display("FAIL cont_write[%0d]: en=%b addr=%0d data=%h, required 1/%0d/%h",
                 i, w_en, w_addr, w_data, exp_a, exp_d);
      end
    end
    cam_valid = 1'b0;
    checks++;
    if (fill_done !== 1'b1) begin
      errors++; $display("FAIL cont_done: got %b, required 1", fill_done);
    end
    cyc();
  endtask

  task automatic test_degenerate();
    start_fill(8'd10, 8'd3, 8'd0, 8'd2, 32'h1);
    checks++;
    if (fill_done !== 1'b1 || fill_busy !== 1'b0 || w_en !== 1'b0) begin
      errors++;
      $display("FAIL degen_done: done=%b busy=%b en=%b, required 1/0/0", fill_done, fill_busy, w_en);
    end
    cyc();
    checks++;
    if (fill_done !== 1'b0 || w_en !== 1'b0) begin
      errors++; $display("FAIL degen_after: done=%b en=%b, required 0/0", fill_done, w_en);
    end
  endtask

  task automatic test_reset_mid_fill();
    start_fill(8'd10, 8'd3, 8'd3, 8'd2, 32'h00FF00FF);
    for (int k = 0; k < 3; k++) cyc();
    checks++;
    if (w_en !== 1'b1 || w_addr !== 15'd540) begin
      errors++; $display("FAIL rst_pre: en=%b addr=%0d, required 1/540", w_en, w_addr);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if (w_en !== 1'b0 || fill_busy !== 1'b0 || fill_done !== 1'b0) begin
      errors++;
      $display("FAIL rst_async: en=%b busy=%b done=%b, required 0/0/0", w_en, fill_busy, fill_done);
    end
    cyc();
    reset_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cyc();
      checks++;
      if (fill_done !== 1'b0 || w_en !== 1'b0) begin
        errors++; $display("FAIL rst_no_done[%0d]: done=%b en=%b, required 0/0", k, fill_done, w_en);
      end
    end
    start_fill(8'd5, 8'd2, 8'd1, 8'd1, 32'hCAFEBABE);
    cyc();
    checks++;
    if (w_en !== 1'b1 || w_addr !== 15'd357 || w_data !== 32'hCAFEBABE || fill_done !== 1'b1) begin
      errors++;
      $display("FAIL rst_refill: en=%b addr=%0d data=%h done=%b, required 1/357/cafebabe/1",
               w_en, w_addr, w_data, fill_done);
    end
    cyc();
  endtask

`ifdef FB_CLIP_EN
  task automatic test_clip();
    start_fill(8'd174, 8'd0, 8'd4, 8'd1, 32'h77);
    for (int k = 0; k < 4; k++) begin
      cyc();
      checks++;
      if (w_en !== (k < 2) || (k < 2 && w_addr !== 15'(174 + k)) || fill_done !== (k == 3)) begin
        errors++;
        $display("FAIL clip[%0d]: en=%b addr=%0d done=%b, required %b/%0d/%b",
                 k, w_en, w_addr, fill_done, k < 2, 174 + k, k == 3);
      end
    end
    cyc();
  endtask
`endif

  initial begin
    test_reset();
    test_camera();
    test_fill(1'b0);
    test_contention();
    test_degenerate();
    test_fill(1'b1);
    test_reset_mid_fill();
`ifdef FB_CLIP_EN
    test_clip();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fb_write_arbiter.md
Name: fb_write_arbiter

Overview:
- Single-clock write-port controller for the 176x144, 32-bit frame-buffer RAM.
- Shares the RAM write port between two requesters:
  - the camera pixel stream (valid/ready);
  - a rectangle-fill engine, used for maze overlays and clears.
- Converts (x,y) to a linear address and drives registered w_addr/w_data/w_en straight into the RAM write port.
- Bounded-starvation arbitration: the camera normally wins, but a pending fill is guaranteed a slot.

Parameters:
- SCREEN_W, 176, pixels per line; address = y*SCREEN_W + x.
- SCREEN_H, 144, lines per frame.
- ADDR_W, 15, RAM address width.
- DATA_W, 32, pixel width.
- MAX_STARVE, 4, maximum consecutive camera grants while a fill pixel is waiting (must be 1..15).

Ports:
- clk  in  1  single clock; also drives the RAM write clock.
- reset_n  in  1  asynchronous, active-low reset.
- cam_valid  in  1  camera pixel available.
- cam_ready  out  1  camera pixel accepted this cycle.
- cam_x  in  8  camera pixel column.
- cam_y  in  8  camera pixel row.
- cam_data  in  DATA_W  camera pixel value.
- fill_start  in  1  one-cycle pulse that launches a rectangle fill.
- fill_x0  in  8  rectangle left column, sampled on fill_start.
- fill_y0  in  8  rectangle top row, sampled on fill_start.
- fill_w  in  8  rectangle width, sampled on fill_start.
- fill_h  in  8  rectangle height, sampled on fill_start.
- fill_color  in  DATA_W  fill value, sampled on fill_start.
- fill_busy  out  1  fill in progress.
- fill_done  out  1  one-cycle pulse when a fill completes.
- w_addr  out  ADDR_W  RAM write address (registered).
- w_data  out  DATA_W  RAM write data (registered).
- w_en  out  1  RAM write enable (registered).

Behaviour:
- Reset (async assert, sync release):
  - outputs: w_en=0, w_addr=0, w_data=0, fill_busy=0, fill_done=0;
  - internal: state=IDLE, starve_cnt=0.
  - Reset asserted mid-fill abandons the fill with no fill_done; writes already issued remain in RAM.
- Fill FSM:
  - IDLE:
    - fill_start with fill_w!=0 and fill_h!=0 -> latch the command, set cx=x0, cy=y0, go to FILL, fill_busy=1 on the next cycle.
    - fill_start with fill_w==0 or fill_h==0 -> DONE; no writes.
  - FILL: one fill pixel is pending every cycle. When it is granted:
    - cx increments;
    - at cx==x0+w-1, cx returns to x0 and cy increments;
    - when the last pixel (x0+w-1, y0+h-1) is granted -> DONE.
  - DONE: fill_done=1 for exactly one cycle, fill_busy=0, return to IDLE.
  - fill_start while fill_busy=1 is ignored.
- Arbitration (combinational, per cycle):
  - fill_grant = (state==FILL) && (!cam_valid || starve_cnt==MAX_STARVE).
  - cam_ready = !fill_grant, so cam_ready=1 whenever no fill is pending.
  - starve_cnt:
    - increments on a camera grant while a fill is pending;
    - clears on any fill grant and in IDLE;
    - saturates at MAX_STARVE.
- Write pipeline: one-cycle latency from grant to the registered outputs.
  - Camera accept (cam_valid && cam_ready) -> next cycle: w_en=1, w_addr=cam_y*SCREEN_W+cam_x, w_data=cam_data.
  - Fill grant -> next cycle: w_en=1, w_addr=cy*SCREEN_W+cx, w_data=fill_color.
  - No grant -> w_en=0; w_addr and w_data hold their previous values.
- Arithmetic:
  - The address product is ADDR_W wide and computed without a multiplier (shift-add for constant SCREEN_W).
  - Fill end coordinates use 9-bit sums, so x0+w overflow is not truncated.

Optional Feature:
- Macro: FB_CLIP_EN.
- Defined:
  - Any granted pixel with x>=SCREEN_W or y>=SCREEN_H suppresses w_en (write dropped).
  - Handshake and fill progress are unchanged, so the fill still walks all w*h pixels.
- Undefined: the address is computed and written unchecked, and the caller guarantees in-range coordinates.

Test Plan:
- Camera only: cam_valid=1 with (x=5, y=2, data=0xAABBCCDD), no fill -> cam_ready=1; next cycle w_en=1, w_addr=357, w_data=0xAABBCCDD.
- Fill only: start x0=10, y0=3, w=3, h=2, color=0x00FF00FF with cam_valid=0 ->
  - six consecutive writes at addresses 538, 539, 540, 714, 715, 716;
  - fill_done pulses once, one cycle after the last grant; fill_busy is high throughout.
- Contention: cam_valid held at 1 during a 2x1 fill with MAX_STARVE=4 ->
  - grant pattern C,C,C,C,F,C,C,C,C,F;
  - cam_ready=0 exactly on the F cycles; no pixel lost.
- Degenerate and ignored commands:
  - fill_start with w=0 -> fill_done one cycle later, zero writes.
  - fill_start while busy -> ignored; the first fill's addresses are unchanged.
- Reset: reset_n low mid-fill (after 3 of 6 pixels) -> w_en=0 and fill_busy=0 immediately, no fill_done; a new fill after release runs normally.
- FB_CLIP_EN defined: fill x0=174, y0=0, w=4, h=1 -> writes only at addresses 174 and 175; fill_done still pulses after 4 grants.
